// File: rtl/ucie_mb_clk_pkg.sv
// Shared types and constants for the mainband forwarded-clock lane logic.
package ucie_mb_clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST_HI = 2'd1,
        BURST_LO = 2'd2,
        DONE     = 2'd3
    } clk_rep_state_t;

    localparam int UCIE_CLK_HIGH_CYC = 32;
    localparam int UCIE_CLK_LOW_CYC  = 16;
    localparam int UCIE_CLK_LANES    = 3;

    // Lane positions within the forwarded-clock bundle.
    localparam int CKP = 0;
    localparam int CKN = 1;
    localparam int TRK = 2;

endpackage

// File: rtl/ucie_clk_lane_mux.sv
// Per-lane selection between the registered repair pattern and the forwarded
// clocks, with strobe-mode gating of the forwarded clocks.
module ucie_clk_lane_mux #(
    parameter int NUM_LANES = 3
) (
    input  logic [NUM_LANES-1:0] fwd_clk,
    input  logic                 mode,
    input  logic                 valid,
    input  logic                 repair,
    input  logic [NUM_LANES-1:0] rep_lane,
    output logic [NUM_LANES-1:0] lane
);

    always_comb begin
        lane = fwd_clk & {NUM_LANES{valid | mode}};
        if (repair) begin
            lane = rep_lane;
        end
    end

endmodule

// File: rtl/ucie_clk_repair_pattern_gen.sv
// Forwarded-clock lane driver: normal-regime clock forwarding, or a counted
// burst pattern on a latched lane subset for clock-lane repair/reversal checks.
module ucie_clk_repair_pattern_gen
    import ucie_mb_clk_pkg::*;
#(
    parameter int NUM_LANES = UCIE_CLK_LANES,
    parameter int HIGH_CYC  = UCIE_CLK_HIGH_CYC,
    parameter int LOW_CYC   = UCIE_CLK_LOW_CYC,
    parameter int CNT_W     = 6,
    parameter int ITER_W    = 13
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_LANES-1:0] i_fwd_clk,
    input  logic                 i_mode,
    input  logic                 i_valid,
    input  logic                 i_repair,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [ITER_W-1:0]    i_iterations,
    input  logic [NUM_LANES-1:0] i_lane_mask,
    output logic [NUM_LANES-1:0] o_lane,
    output logic [NUM_LANES-1:0] o_det_en,
    output logic                 o_busy,
    output logic                 o_done
);

    // Control protocol: i_start is a request accepted only in IDLE (no ready
    // handshake; starts elsewhere are dropped). i_abort wins over everything
    // and ends the sequence silently. o_done pulses once per completed run.
    clk_rep_state_t       state_q, state_d;
    logic                 phase_q, phase_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    logic [ITER_W-1:0]    burst_q, burst_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic [NUM_LANES-1:0] det_en_q, det_en_d;
    logic [NUM_LANES-1:0] rep_lane;

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            cyc_q    <= '0;
            burst_q  <= '0;
            iter_q   <= '0;
            mask_q   <= '0;
            det_en_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cyc_q    <= cyc_d;
            burst_q  <= burst_d;
            iter_q   <= iter_d;
            mask_q   <= mask_d;
            det_en_q <= det_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cyc_d   = cyc_q;
        burst_d = burst_q;
        iter_d  = iter_q;
        mask_d  = mask_q;
        if (i_abort) begin
            state_d = IDLE;
            phase_d = 1'b0;
            cyc_d   = '0;
            burst_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        mask_d  = i_lane_mask;
                        iter_d  = i_iterations;
                        phase_d = 1'b0;
                        cyc_d   = '0;
                        burst_d = '0;
                        state_d = (i_iterations == '0) ? DONE : BURST_HI;
                    end
                end
                BURST_HI: begin
                    // An even toggle count leaves phase low on the hand-off.
                    phase_d = ~phase_q;
                    if (cyc_q == CNT_W'(HIGH_CYC - 1)) begin
                        cyc_d   = '0;
                        state_d = BURST_LO;
                    end else begin
                        cyc_d = cyc_q + CNT_W'(1);
                    end
                end
                BURST_LO: begin
                    phase_d = 1'b0;
                    if (cyc_q == CNT_W'(LOW_CYC - 1)) begin
                        cyc_d = '0;
                        // iter_q is nonzero here, so iter_q - 1 cannot wrap.
                        if (burst_q == iter_q - ITER_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            burst_d = burst_q + ITER_W'(1);
                            state_d = BURST_HI;
                        end
                    end else begin
                        cyc_d = cyc_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        det_en_d = ((state_d == BURST_HI) || (state_d == BURST_LO)) ? mask_d : '0;
    end

    assign rep_lane = phase_q ? mask_q : '0;
    assign o_det_en = det_en_q;
    assign o_busy   = (state_q == BURST_HI) || (state_q == BURST_LO);
    assign o_done   = (state_q == DONE);

    ucie_clk_lane_mux #(
        .NUM_LANES (NUM_LANES)
    ) u_lane_mux (
        .fwd_clk  (i_fwd_clk),
        .mode     (i_mode),
        .valid    (i_valid),
        .repair   (i_repair),
        .rep_lane (rep_lane),
        .lane     (o_lane)
    );

endmodule

// File: tb/tb_ucie_clk_repair_pattern_gen.sv
// Directed bench for ucie_clk_repair_pattern_gen at default parameters.
module tb_ucie_clk_repair_pattern_gen;

    localparam int NL    = 3;
    localparam int IW    = 13;
    localparam int BURST = 48;  // 32 toggle cycles + 16 low cycles

    logic          i_sys_clk;
    logic          i_rst_n;
    logic [NL-1:0] i_fwd_clk;
    logic          i_mode;
    logic          i_valid;
    logic          i_repair;
    logic          i_start;
    logic          i_abort;
    logic [IW-1:0] i_iterations;
    logic [NL-1:0] i_lane_mask;
    logic [NL-1:0] o_lane;
    logic [NL-1:0] o_det_en;
    logic          o_busy;
    logic          o_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    ucie_clk_repair_pattern_gen dut (
        .i_sys_clk    (i_sys_clk),
        .i_rst_n      (i_rst_n),
        .i_fwd_clk    (i_fwd_clk),
        .i_mode       (i_mode),
        .i_valid      (i_valid),
        .i_repair     (i_repair),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_iterations (i_iterations),
        .i_lane_mask  (i_lane_mask),
        .o_lane       (o_lane),
        .o_det_en     (o_det_en),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // Clock and reset
    initial i_sys_clk = 1'b0;
    always #5 i_sys_clk = ~i_sys_clk;

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs_word();
        return {o_done, o_busy, o_det_en, o_lane};
    endfunction

    // Expected {done, busy, det_en, lane} right after edge k, edge 0 = start edge.
    function automatic logic [7:0] model_word(input logic [2:0] mask, input int iters,
                                              input int k, input int abort_at);
        int  r;
        logic ph;
        if (abort_at >= 0 && k >= abort_at) return 8'h00;
        if (k < iters * BURST) begin
            r  = k % BURST;
            ph = (r < 32) && (r % 2 == 1);
            return {1'b0, 1'b1, mask, (ph ? mask : 3'b000)};
        end
        if (k == iters * BURST) return 8'h80;
        return 8'h00;
    endfunction

    // Driver: start at edge 0, optional abort and disturbing re-start.
    task automatic run_seq(input string tag, input logic [2:0] mask, input int iters,
                           input int abort_at, input int restart_at);
        int last;
        last = (abort_at >= 0) ? abort_at + 4 : iters * BURST + 3;
        for (int k = 0; k <= last; k++) begin
            i_start = 1'b0;
            if (k == 0) begin
                i_start      = 1'b1;
                i_lane_mask  = mask;
                i_iterations = IW'(iters);
            end
            if (k == restart_at) begin
                i_start      = 1'b1;
                i_lane_mask  = ~mask;
                i_iterations = IW'(iters + 3);
            end
            i_abort = (k == abort_at);
            exp_q.push_back(model_word(mask, iters, k, abort_at));
            tick();
            check_eq($sformatf("%s@%0d", tag, k), {24'd0, obs_word()}, {24'd0, exp_q.pop_front()});
        end
        i_start = 1'b0;
        i_abort = 1'b0;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_fwd_clk    = '0;
        i_mode       = 1'b0;
        i_valid      = 1'b0;
        i_repair     = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_iterations = '0;
        i_lane_mask  = '0;
        repeat (2) tick();
        check_eq("reset_outputs", {24'd0, obs_word()}, 32'd0);
        i_rst_n = 1'b1;
        tick();
        check_eq("idle_after_reset", {24'd0, obs_word()}, 32'd0);

        run_seq("two_bursts_all", 3'b111, 2, -1, -1);
        run_seq("one_burst_lane1", 3'b010, 1, -1, -1);
        run_seq("zero_iter", 3'b111, 0, -1, -1);
        run_seq("abort_e40", 3'b111, 4, 40, -1);
        run_seq("after_abort", 3'b111, 2, -1, -1);
        run_seq("restart_ignored", 3'b101, 2, -1, 20);

        // Abort together with start in IDLE: nothing happens
        i_lane_mask  = 3'b111;
        i_iterations = IW'(1);
        i_start      = 1'b1;
        i_abort      = 1'b1;
        tick();
        check_eq("start_abort_idle", {24'd0, obs_word()}, 32'd0);
        i_start = 1'b0;
        i_abort = 1'b0;
        tick();
        check_eq("start_abort_idle2", {24'd0, obs_word()}, 32'd0);

        // Normal regime forwarding and strobe gating
        i_repair  = 1'b0;
        i_fwd_clk = 3'b101;
        i_mode    = 1'b0;
        i_valid   = 1'b0;
        #1 check_eq("strobe_gated", {29'd0, o_lane}, 32'd0);
        i_valid = 1'b1;
        #1 check_eq("strobe_pass_101", {29'd0, o_lane}, 32'h5);
        i_fwd_clk = 3'b011;
        #1 check_eq("strobe_pass_011", {29'd0, o_lane}, 32'h3);
        i_mode  = 1'b1;
        i_valid = 1'b0;
        #1 check_eq("cont_011", {29'd0, o_lane}, 32'h3);
        i_fwd_clk = 3'b110;
        #1 check_eq("cont_110", {29'd0, o_lane}, 32'h6);

        // Repair deselected mid-sequence: FSM keeps running, lanes forward
        i_repair     = 1'b1;
        i_lane_mask  = 3'b111;
        i_iterations = IW'(1);
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (5) tick();
        i_repair  = 1'b0;
        i_fwd_clk = 3'b100;
        #1;
        check_eq("unsel_lane", {29'd0, o_lane}, 32'h4);
        check_eq("unsel_busy", {31'd0, o_busy}, 32'd1);
        for (int k = 6; k <= BURST; k++) tick();
        check_eq("unsel_done", {30'd0, o_done, o_busy}, 32'h2);
        tick();
        check_eq("unsel_done_once", {31'd0, o_done}, 32'd0);

        // Asynchronous reset mid-burst
        i_repair     = 1'b1;
        i_iterations = IW'(2);
        i_start      = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (11) tick();
        check_eq("pre_rst_word", {24'd0, obs_word()}, {24'd0, model_word(3'b111, 2, 11, -1)});
        #2 i_rst_n = 1'b0;
        #1 check_eq("async_rst_word", {24'd0, obs_word()}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check_eq("post_rst_idle", {24'd0, obs_word()}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ucie_clk_repair_pattern_gen.md
Name: ucie_clk_repair_pattern_gen

Overview:
- Parametrised successor of the mainband clock-lane pattern generator. Drives NUM_LANES forwarded-clock lanes (default 3: CKP, CKN, TRACK).
- Two operating regimes:
  - Normal (i_repair=0): combinational forwarding of per-lane clocks, gated in strobe mode.
  - Repair (i_repair=1): a start-triggered FSM emits a programmable count of bursts (HIGH_CYC toggles, then LOW_CYC low cycles) on a masked lane subset, with per-lane detector enables, abort, and a one-cycle done pulse.
- Sits between the MB clock tx path and the lane-repair/detector logic in the MBINIT REPAIRCLK and REVERSALMB flows.

Parameters:
- NUM_LANES, 3: number of clock lanes driven.
- HIGH_CYC, 32: i_sys_clk cycles per burst toggle phase. Must be even and >=2.
- LOW_CYC, 16: i_sys_clk cycles per burst low phase. Must be >=1.
- CNT_W, 6: intra-burst counter width. Must satisfy 2^CNT_W > max(HIGH_CYC, LOW_CYC).
- ITER_W, 13: burst-count width.

Ports:
- i_sys_clk  in  1  block clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_fwd_clk  in  NUM_LANES  per-lane forwarded clocks for normal regime.
- i_mode  in  1  0 = strobe, 1 = continuous.
- i_valid  in  1  strobe-mode gate.
- i_repair  in  1  selects repair regime for lane outputs.
- i_start  in  1  start a repair sequence; sampled only in IDLE.
- i_abort  in  1  abort the sequence; returns to IDLE with no done.
- i_iterations  in  ITER_W  number of bursts to send; latched at start.
- i_lane_mask  in  NUM_LANES  lanes that carry the pattern; latched at start.
- o_lane  out  NUM_LANES  lane outputs.
- o_det_en  out  NUM_LANES  per-lane detector enables.
- o_busy  out  1  high in BURST_HI and BURST_LO.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: FSM=IDLE; phase, counters, latched mask, o_det_en, o_busy and o_done all 0. o_lane follows the regime mux; in repair regime it is 0.
- Normal regime, combinational:
  - o_lane[i] = i_mode ? i_fwd_clk[i] : (i_valid & i_fwd_clk[i]).
  - The FSM may still run, but its output is not selected.
- Repair regime: o_lane[i] = phase_q & mask_q[i]. Registered; no glitches.
- FSM states: IDLE, BURST_HI, BURST_LO, DONE.
- IDLE:
  - On i_start & !i_abort: latch mask_q and iter_q; clear phase, cyc_cnt and burst_cnt.
  - If i_iterations==0, go to DONE; otherwise go to BURST_HI.
- BURST_HI, each edge:
  - phase toggles and cyc_cnt increments.
  - At cyc_cnt==HIGH_CYC-1: clear cyc_cnt and go to BURST_LO. Because HIGH_CYC is even, phase ends at 0.
- BURST_LO, each edge:
  - phase=0 and cyc_cnt increments.
  - At cyc_cnt==LOW_CYC-1: clear cyc_cnt. If burst_cnt==iter_q-1, go to DONE; otherwise increment burst_cnt and go to BURST_HI.
- DONE: o_done=1 for exactly this one cycle, then IDLE. o_det_en is already 0 here.
- o_det_en = mask_q, registered, set while in BURST_HI or BURST_LO; 0 otherwise.
- Per burst, each masked lane shows HIGH_CYC/2 rising edges and is held low for LOW_CYC cycles. Total sequence = i_iterations*(HIGH_CYC+LOW_CYC) cycles from the start edge to the DONE entry edge.
- i_start while not in IDLE: ignored. Changes to i_iterations or i_lane_mask mid-sequence: ignored.
- i_abort:
  - In any state, it has priority: next state IDLE, phase and counters cleared, o_det_en=0, no o_done.
  - i_abort and i_start together in IDLE: stay in IDLE.
- i_repair deasserted mid-sequence: the FSM continues, but its output is unselected. Only i_abort stops the sequence.
- Counter wrap: burst_cnt is ITER_W wide. The maximum i_iterations=2^ITER_W-1 must terminate correctly, with no wrap.
- Asynchronous reset mid-sequence: immediate IDLE, all outputs per the reset state.

Decomposition:
- Package ucie_mb_clk_pkg holds:
  - the FSM state enum clk_rep_state_t;
  - default constants UCIE_CLK_HIGH_CYC=32, UCIE_CLK_LOW_CYC=16, UCIE_CLK_LANES=3;
  - lane index constants CKP=0, CKN=1, TRK=2.
- Optional sub-module ucie_clk_lane_mux: per-lane normal/repair selection and strobe gating. Everything else stays flat.

Test Plan:
- Defaults, i_repair=1, i_lane_mask=3'b111, i_iterations=2, start pulse at edge 0 ->
  - o_busy for edges 1..96;
  - each lane shows 32 rising edges, with low windows at edges 33..48 and 81..96;
  - o_done high exactly one cycle after edge 96.
- i_lane_mask=3'b010, i_iterations=1 -> only lane 1 toggles (16 rising edges); lanes 0 and 2 stay 0; o_det_en=3'b010 during busy.
- i_iterations=0 -> no toggling, o_busy never high, o_done pulses the cycle after the start edge.
- i_abort at edge 40 of a 4-burst run -> IDLE next edge; o_lane=0, o_det_en=0; no o_done. A new i_start then produces a full sequence.
- i_start re-pulsed at edge 20 while busy, plus i_lane_mask changed -> no effect; sequence length and lanes unchanged.
- i_repair=0 with i_mode=0:
  - i_valid=0 -> o_lane=0;
  - i_valid=1 -> o_lane equals i_fwd_clk;
  - i_mode=1 -> forwarding regardless of i_valid.
  - Async reset asserted mid-burst -> all outputs 0 immediately.
